// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Bundles the instruction-memory request/response channel and the
//   fetch-to-decode channel of the fetch stage.
//
//   Handshake semantics (both directions):
//     A request transfers on a rising edge where valid && ready are both high.
//     The fetch unit may withdraw imem_req_valid without a transfer (on redirect),
//     so memory must not assume valid stays high until ready.
//     The response channel has no backpressure: imem_rsp_valid is a one-cycle
//     strobe carrying imem_rdata.
//     if_valid / if_ready: decode consumes {if_instr, if_pc} on valid && ready.
//
//   Modports:
//     master - the fetch unit (drives requests and the decode-side payload)
//     slave  - memory/decode environment
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage of the sequential RV32I core. Owns the PC, keeps at
//   most one instruction-memory read outstanding, and presents {instr, pc} to
//   decode. A redirect (taken branch/jump from execute) reloads the PC with
//   priority over everything else.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus               fetch_unit_if.master: imem request/response + decode side
//   redirect          taken branch/jump this cycle
//   redirect_target   new PC
//   misalign_trap     sticky misaligned-redirect flag (FETCH_MISALIGN_TRAP_EN only)
//   dbg_state         current FSM state for observation
//
// Configuration macro: FETCH_MISALIGN_TRAP_EN
//   undefined: redirect_target[1:0] is forced to 00.
//   defined  : a misaligned redirect parks the unit in TRAP until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      bus,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              misalign_trap,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_TRAP = 3'd4
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] instr_q, instr_d;
  // kill: the outstanding read belongs to a PC that a redirect has abandoned.
  logic        kill, kill_d;
  logic [31:0] tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Only aligned targets reach tgt's users; misaligned ones divert to TRAP.
  assign tgt = redirect_target;
`else
  logic unused_tgt_bits;
  assign tgt             = {redirect_target[31:2], 2'b00};
  assign unused_tgt_bits = ^redirect_target[1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      kill    <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      instr_q <= instr_d;
      kill    <= kill_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr_q;
    kill_d  = kill;
    case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = tgt;
      end
      S_REQ: begin
        // Request is withdrawn during a redirect, so no handshake can occur.
        if (redirect)                pc_d    = tgt;
        else if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d   = tgt;
          kill_d = 1'b1;
        end
        if (bus.imem_rsp_valid) begin
          if (kill || redirect) begin
            // Stale data for an abandoned PC: drop it and refetch.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A redirect wins over a same-cycle consume; the held word is dropped.
        if (redirect) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (bus.if_ready) begin
          pc_d    = pc + 32'd4;
          state_d = S_REQ;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (state != S_TRAP && redirect && redirect_target[1:0] != 2'b00) begin
      state_d = S_TRAP;
      pc_d    = redirect_target;
      kill_d  = 1'b0;
    end
`endif
  end

  assign bus.imem_req_valid = (state == S_REQ) && !redirect;
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = (state == S_HOLD) && !redirect;
  assign bus.if_instr       = instr_q;
  assign bus.if_pc          = pc;
  assign dbg_state          = state;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap      = (state == S_TRAP);
`endif

endmodule
